// File: rtl/debounce_pkg.sv
//==============================================================================
// Module  : debounce_pkg
// Brief   : State encoding and helpers shared by the switch debouncer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package debounce_pkg;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'b00,
        ST_WAIT1 = 2'b01,
        ST_ONE   = 2'b10,
        ST_WAIT0 = 2'b11
    } state_e;

    // WAIT0 still reports high: the level only drops once the release is proven stable.
    function automatic logic state_is_high(input state_e s);
        return (s == ST_ONE) || (s == ST_WAIT0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/switch_debouncer_sync_ff.sv
//==============================================================================
// Module  : sync_ff
// Brief   : Plain flop-chain synchroniser for an asynchronous single-bit input.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/switch_debouncer.sv
//==============================================================================
// Module  : switch_debouncer
// Brief   : Synchronise and debounce a mechanical switch; registered level and
//           rising-edge tick. Define DEBOUNCE_FALL_EN to add db_fall_tick.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int TICKS       = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic db_level,
`ifdef DEBOUNCE_FALL_EN
    output logic db_fall_tick,
`endif
    output logic db_tick
);

    localparam int               CNT_W    = $clog2(TICKS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TICKS - 1);

    logic             sw_sync;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_level_q, db_level_d;
    logic             db_tick_q, db_tick_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_in),
        .q   (sw_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_ZERO: begin
                if (sw_sync) begin
                    state_d = ST_WAIT1;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT1: begin
                if (!sw_sync)           state_d = ST_ZERO;
                else if (cnt_q == '0)   state_d = ST_ONE;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_ONE: begin
                if (!sw_sync) begin
                    state_d = ST_WAIT0;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT0: begin
                if (sw_sync)            state_d = ST_ONE;
                else if (cnt_q == '0)   state_d = ST_ZERO;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_ZERO;
        endcase

        db_level_d = state_is_high(state_d);
        db_tick_d  = (state_q == ST_WAIT1) && (state_d == ST_ONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_ZERO;
            cnt_q      <= '0;
            db_level_q <= 1'b0;
            db_tick_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            db_level_q <= db_level_d;
            db_tick_q  <= db_tick_d;
        end
    end

    assign db_level = db_level_q;
    assign db_tick  = db_tick_q;

`ifdef DEBOUNCE_FALL_EN
    logic db_fall_tick_q, db_fall_tick_d;

    always_comb begin
        db_fall_tick_d = (state_q == ST_WAIT0) && (state_d == ST_ZERO);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            db_fall_tick_q <= 1'b0;
        end else begin
            db_fall_tick_q <= db_fall_tick_d;
        end
    end

    assign db_fall_tick = db_fall_tick_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
//==============================================================================
// Module  : tb_switch_debouncer
// Brief   : Self-checking bench for switch_debouncer (TICKS=8, SYNC_STAGES=2).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_switch_debouncer;

    typedef struct {
        logic rst;
        logic sw;
        int   n;
        logic lvl;
        logic tick;
        logic fall;
    } vec_t;

    typedef struct {
        logic lvl;
        logic tick;
        logic fall;
        int   idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sw_in = 1'b1;
    logic db_level;
    logic db_tick;
`ifdef DEBOUNCE_FALL_EN
    logic db_fall_tick;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    switch_debouncer #(
        .TICKS       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_in        (sw_in),
        .db_level     (db_level),
`ifdef DEBOUNCE_FALL_EN
        .db_fall_tick (db_fall_tick),
`endif
        .db_tick      (db_tick)
    );

    // Outputs settle after each edge; compare against the oldest pending expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (db_level !== e.lvl) begin
                n_fail++;
                $display("FAIL db_level vec%0d t=%0t: got %b expected %b", e.idx, $time, db_level, e.lvl);
            end
            n_checks++;
            if (db_tick !== e.tick) begin
                n_fail++;
                $display("FAIL db_tick vec%0d t=%0t: got %b expected %b", e.idx, $time, db_tick, e.tick);
            end
`ifdef DEBOUNCE_FALL_EN
            n_checks++;
            if (db_fall_tick !== e.fall) begin
                n_fail++;
                $display("FAIL db_fall_tick vec%0d t=%0t: got %b expected %b", e.idx, $time, db_fall_tick, e.fall);
            end
`endif
        end
    end

    // Each record holds its inputs for n edges; expectations are outputs after each of those edges.
    function automatic void add(logic r, logic s, int n, logic l, logic t, logic f);
        vec_t v;
        v.rst = r; v.sw = s; v.n = n; v.lvl = l; v.tick = t; v.fall = f;
        vecs.push_back(v);
    endfunction

    initial begin
        exp_t e;

        // reset held with switch pressed
        add(0, 1, 5, 0, 0, 0);
        // clean press: level and tick 10 edges after first sample
        add(1, 0, 3, 0, 0, 0);
        add(1, 1, 10, 0, 0, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 1, 3, 1, 0, 0);
        // short release glitch while in ONE
        add(1, 0, 3, 1, 0, 0);
        add(1, 1, 6, 1, 0, 0);
        // full release: exact 10-edge latency proves FSM was back in ONE
        add(1, 0, 10, 1, 0, 0);
        add(1, 0, 1, 0, 0, 1);
        add(1, 0, 3, 0, 0, 0);
        // bounce during WAIT1 restarts filtering from the last rise
        add(1, 1, 5, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0);
        add(1, 1, 10, 0, 0, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 1, 2, 1, 0, 0);
        // release, then reset mid-WAIT1 with switch held
        add(1, 0, 10, 1, 0, 0);
        add(1, 0, 1, 0, 0, 1);
        add(1, 0, 3, 0, 0, 0);
        add(1, 1, 5, 0, 0, 0);
        add(0, 1, 2, 0, 0, 0);
        add(1, 1, 10, 0, 0, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 1, 2, 1, 0, 0);
        // reset in ONE, switch held across release
        add(0, 1, 1, 0, 0, 0);
        add(1, 1, 10, 0, 0, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 1, 3, 1, 0, 0);
        // reset mid-WAIT0: level drops, no fall tick
        add(1, 0, 4, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        add(1, 0, 4, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                @(negedge clk);
                rst   = vecs[i].rst;
                sw_in = vecs[i].sw;
                e.lvl  = vecs[i].lvl;
                e.tick = vecs[i].tick;
                e.fall = vecs[i].fall;
                e.idx  = i;
                exp_q.push_back(e);
            end
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
